ula_multiciclo: RTL and testbench



---
 rtl/ula_multiciclo.sv | 162 ++++++++++++++++
 tb/tb_ula_multiciclo.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ula_multiciclo.sv
// Multi-cycle MIPS ALU: add/sub/slt finish in one edge, signed mult/div run
// WIDTH iterations on magnitudes and then take a sign-fix cycle.
module ula_multiciclo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       alu_con,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             div0,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             op_div;
    logic             sign_q;
    logic             sign_r;
    logic             b_is0;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] a_lat;

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [WIDTH-1:0]        mag_a_in;
    logic [WIDTH-1:0]        mag_b_in;
    logic [WIDTH-1:0]        quick;
    logic                    is_long;

    assign a_s      = a;
    assign b_s      = b;
    assign mag_a_in = a[WIDTH-1] ? -a : a;
    assign mag_b_in = b[WIDTH-1] ? -b : b;
    assign is_long  = (alu_con[2:1] == 2'b01);

    always_comb begin
        quick = '0;
        case (alu_con)
            3'b000:  quick = a + b;
            3'b001:  quick = a - b;
            3'b100:  quick = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            default: quick = '0;
        endcase
    end

    // Mult: {acc_hi,acc_lo} is the product/multiplier pair, shifted right each step.
    // Div: acc_hi is the partial remainder, acc_lo the dividend turning into the quotient.
    logic [WIDTH:0] msum;
    logic [WIDTH:0] rsh;
    logic [WIDTH:0] rdiff;
    logic           ge;

    assign msum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : {(WIDTH+1){1'b0}});
    assign rsh   = {acc_hi, acc_lo[WIDTH-1]};
    assign ge    = (rsh >= {1'b0, mag_b});
    assign rdiff = rsh - {1'b0, mag_b};

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fix_res;
    logic [WIDTH-1:0]   fix_hi;

    assign prod     = {acc_hi, acc_lo};
    assign prod_fix = sign_q ? -prod : prod;

    always_comb begin
        fix_res = prod_fix[WIDTH-1:0];
        fix_hi  = prod_fix[2*WIDTH-1:WIDTH];
        if (op_div) begin
            if (b_is0) begin
                fix_res = '1;
                fix_hi  = a_lat;
            end else begin
                fix_res = sign_q ? -acc_lo : acc_lo;
                fix_hi  = sign_r ? -acc_hi : acc_hi;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            op_div <= 1'b0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            b_is0  <= 1'b0;
            mag_b  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            a_lat  <= '0;
            result <= '0;
            hi     <= '0;
            zero   <= 1'b0;
            div0   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_long) begin
                            op_div <= alu_con[0];
                            sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
                            sign_r <= a[WIDTH-1];
                            b_is0  <= (b == '0);
                            mag_b  <= mag_b_in;
                            acc_hi <= '0;
                            acc_lo <= mag_a_in;
                            a_lat  <= a;
                            cnt    <= '0;
                            busy   <= 1'b1;
                            state  <= CALC;
                        end else begin
                            result <= quick;
                            zero   <= (quick == '0);
                            done   <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (op_div) begin
                        acc_hi <= ge ? rdiff[WIDTH-1:0] : rsh[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], ge};
                    end else begin
                        acc_hi <= msum[WIDTH:1];
                        acc_lo <= {msum[0], acc_lo[WIDTH-1:1]};
                    end
                    if (cnt == CW'(WIDTH-1))
                        state <= FIX;
                end
                FIX: begin
                    result <= fix_res;
                    hi     <= fix_hi;
                    zero   <= (fix_res == '0);
                    if (op_div)
                        div0 <= b_is0;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_multiciclo.sv
// Directed bench for ula_multiciclo: expected results are queued when an
// operation is issued and popped when done is seen.
module tb_ula_multiciclo;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   alu_con = 3'b000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] result;
    logic [W-1:0] hi;
    logic         zero;
    logic         div0;
    logic         busy;
    logic         done;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string        tag;
        logic [W-1:0] res;
        logic [W-1:0] hiv;
        logic         z;
        logic         d0;
    } exp_t;

    exp_t sb[$];

    ula_multiciclo #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .alu_con(alu_con),
        .a(a), .b(b), .result(result), .hi(hi), .zero(zero),
        .div0(div0), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] req);
        vectors++;
        assert (obs === req) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, req);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input string tag, input logic [W-1:0] er, input logic [W-1:0] eh,
                         input logic ez, input logic ed);
        exp_t e;
        start   = 1'b1;
        alu_con = op;
        a       = va;
        b       = vb;
        e.tag = tag; e.res = er; e.hiv = eh; e.z = ez; e.d0 = ed;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            check("queue_empty", 72'd1, 72'd0);
        end else begin
            e = sb.pop_front();
            check({e.tag, "_result"}, 72'(result), 72'(e.res));
            check({e.tag, "_hi"},     72'(hi),     72'(e.hiv));
            check({e.tag, "_zero"},   72'(zero),   72'(e.z));
            check({e.tag, "_div0"},   72'(div0),   72'(e.d0));
        end
    endtask

    // Ticks until done rises; n counts edges since the accept edge.
    task automatic wait_done(input int already, input int lat, input string tag);
        int n;
        int bd;
        n  = already;
        bd = 0;
        while (n < lat + 10) begin
            tick();
            n++;
            if (done) break;
            if (!busy) bd++;
        end
        check({tag, "_latency"}, 72'(n), 72'(lat));
        check({tag, "_busy_held"}, 72'(bd), 72'd0);
        check_out();
    endtask

    initial begin
        // Power-on reset
        tick();
        tick();
        check("reset_outputs", 72'({result, hi, zero, div0, busy, done}), 72'd0);
        rst_n = 1'b1;

        // Reset in the middle of a multiply
        start = 1'b1; alu_con = 3'b010; a = 32'd7; b = 32'd9;
        tick();
        start = 1'b0;
        check("mult_busy", 72'(busy), 72'd1);
        for (int i = 0; i < 9; i++) tick();
        rst_n = 1'b0;
        #1;
        check("async_reset", 72'({result, hi, zero, div0, busy, done}), 72'd0);
        tick();
        rst_n = 1'b1;
        issue(3'b000, 32'd3, 32'd4, "add_after_reset", 32'd7, 32'd0, 1'b0, 1'b0);
        tick();
        check("add_done", 72'(done), 72'd1);
        check_out();

        // Back-to-back single-cycle ops
        issue(3'b000, 32'h7FFFFFFF, 32'd1, "add_wrap", 32'h80000000, 32'd0, 1'b0, 1'b0);
        tick();
        check("b2b_done0", 72'(done), 72'd1);
        check_out();
        issue(3'b001, 32'd5, 32'd5, "sub_zero", 32'd0, 32'd0, 1'b1, 1'b0);
        tick();
        check("b2b_done1", 72'(done), 72'd1);
        check_out();
        issue(3'b100, 32'hFFFFFFFF, 32'd1, "slt_signed", 32'd1, 32'd0, 1'b0, 1'b0);
        tick();
        check("b2b_done2", 72'(done), 72'd1);
        check_out();
        issue(3'b110, 32'd12, 32'd34, "reserved", 32'd0, 32'd0, 1'b1, 1'b0);
        tick();
        check("b2b_done3", 72'(done), 72'd1);
        check_out();
        start = 1'b0;
        tick();
        check("done_drops", 72'(done), 72'd0);

        // mult -6*7 with a stray start at edge +5
        issue(3'b010, 32'hFFFFFFFA, 32'd7, "mult_neg", 32'hFFFFFFD6, 32'hFFFFFFFF, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        start = 1'b1; alu_con = 3'b000; a = 32'd1; b = 32'd1;
        tick();
        start = 1'b0;
        wait_done(5, 33, "mult_neg");
        tick();
        check("mult_done_pulse", 72'(done), 72'd0);

        // div -7/2 and divide by zero
        issue(3'b011, 32'hFFFFFFF9, 32'd2, "div_neg", 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        wait_done(0, 33, "div_neg");
        tick();
        issue(3'b011, 32'd100, 32'd0, "div_by0", 32'hFFFFFFFF, 32'd100, 1'b0, 1'b1);
        tick();
        start = 1'b0;
        wait_done(0, 33, "div_by0");
        tick();

        // Most-negative boundaries (mult keeps div0 from the previous div)
        issue(3'b010, 32'h80000000, 32'h80000000, "mult_minmin", 32'd0, 32'h40000000, 1'b1, 1'b1);
        tick();
        start = 1'b0;
        wait_done(0, 33, "mult_minmin");
        tick();
        issue(3'b011, 32'h80000000, 32'hFFFFFFFF, "div_minneg1", 32'h80000000, 32'd0, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        wait_done(0, 33, "div_minneg1");
        tick();

        // start held high across two divides
        issue(3'b011, 32'd100, 32'd7, "div_hold1", 32'd14, 32'd2, 1'b0, 1'b0);
        tick();
        wait_done(0, 33, "div_hold1");
        a = 32'hFFFFFF9C;
        issue(3'b011, 32'hFFFFFF9C, 32'd7, "div_hold2", 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b0);
        tick();
        check("hold_edge34_busy", 72'(busy), 72'd0);
        tick();
        check("hold_edge35_busy", 72'(busy), 72'd1);
        start = 1'b0;
        wait_done(0, 33, "div_hold2");
        tick();
        issue(3'b000, 32'd2, 32'd3, "add_keeps_hi", 32'd5, 32'hFFFFFFFE, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        check("add_keeps_hi_done", 72'(done), 72'd1);
        check_out();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
